eth_reset_sequencer: RTL and testbench
======================================

// Module: eth_reset_sequencer
// PURPOSE
//  Multi-channel programmable reset-pulse generator for the Ethernet path.
//  Each channel waits a programmed delay after a trigger, then drives a reset
//  pulse of programmed width. Channels run one-shot or re-armable.
//  Sits between control/status registers and the MAC/PHY reset pins. One
//  instance sequences PHY, MAC and FIFO resets independently.
// PARAMETERS
//  NUM_CH          3   number of independent channels (1..16)
//  TIMER_W         14  width of each per-channel delay field
//  WIDTH_W         14  width of each per-channel pulse-width field
//  TRIG_LEVEL      0   trigger active level; edge = transition into this level
//  OUT_ACTIVE_LOW  0   1: rst_out asserts low; inactive level = !asserted
//  ONESHOT         1   1: only first trigger after aresetn honoured; 0: re-armable
// PORTS
//  clk        in   1                clock
//  aresetn    in   1                async active-low reset
//  trig       in   NUM_CH           per-channel trigger, synchronous to clk
//  cancel     in   NUM_CH           per-channel abort, active high
//  reset_after in  NUM_CH*TIMER_W   delay per channel, ch i at [i*TIMER_W +: TIMER_W]
//  reset_width in  NUM_CH*WIDTH_W   pulse width per channel, same packing
//  rst_out    out  NUM_CH           reset pulse; polarity set by OUT_ACTIVE_LOW
//  busy       out  NUM_CH           1 while channel is in WAIT or PULSE
//  done       out  NUM_CH           sticky; 1 after pulse finished (ONESHOT) / 1-cycle strobe (re-arm)
//  missed     out  NUM_CH           sticky; trigger edge seen while busy or after one-shot spent
// BEHAVIOUR
//  - Clock is clk. Reset is aresetn: asynchronous, active-low. All flops are
//    cleared asynchronously. Reset values: rst_out is at its inactive level;
//    busy, done and missed are 0; state is IDLE; trig_prev is !TRIG_LEVEL.
//  - Edge detect: an edge occurs when trig==TRIG_LEVEL and trig_prev!=TRIG_LEVEL.
//    Because of the trig_prev reset value, a trigger held active through reset
//    release fires once.
//  - States per channel: IDLE -> WAIT -> PULSE -> DONE.
//    IDLE: an edge latches reset_after/reset_width into channel registers.
//      Later input changes do not affect the running sequence.
//      Go to WAIT with cnt=after. If after==0, go directly to PULSE.
//    WAIT: cnt decrements each cycle. When cnt==1, go to PULSE next cycle.
//    PULSE: rst_out is asserted for exactly width cycles, then go to DONE.
//      If width==0, rst_out is never asserted and the channel goes straight to DONE.
//    DONE: with ONESHOT=1, the channel stays here until aresetn.
//      With ONESHOT=0, the channel returns to IDLE the next cycle.
//  - Latency: if the trigger is sampled at edge k, rst_out asserts at edge
//    k+1+after and deasserts at edge k+1+after+width.
//  - busy is 1 exactly while in WAIT or PULSE.
//  - done (ONESHOT=1): set on entry to DONE and held.
//  - done (ONESHOT=0): 1-cycle strobe on entry to DONE.
//  - Edge during WAIT/PULSE, or in DONE with ONESHOT=1: the edge is ignored,
//    missed is set, and the sequence continues unaffected.
//  - cancel (highest priority, any state):
//    - next cycle the channel is in IDLE and rst_out is inactive;
//    - done is not set; missed is unaffected;
//    - a cancelled ONESHOT channel is re-armed;
//    - cancel and an edge in the same cycle: cancel wins and the edge is dropped.
//  - Counter width is max(TIMER_W,WIDTH_W). No wrap: the all-ones delay and
//    width give 2^W-1 cycles, terminal count exact.
//  - Channels are fully independent; simultaneous triggers on all channels are legal.
//  - An aresetn assertion mid-sequence drops rst_out inactive immediately
//    (async) and clears all sticky flags.
// STRUCTURE
//  - Package eth_reset_pkg: typedef enum logic [1:0] {IDLE,WAIT,PULSE,DONE}
//    rst_state_t; function cnt_w() returning max(TIMER_W,WIDTH_W).
//  - Sub-module eth_reset_chan: one channel FSM, edge detect, counter and flags.
//    The top module is a generate loop over NUM_CH plus port slicing.
// TESTING
//  1 ch0 after=3 width=4, trig edge at cycle 10 -> rst_out active cycles 14..17;
//    busy 11..17; done=1 from 18.
//  2 after=0 width=1 -> 1-cycle pulse at edge k+1.
//    after=5 width=0 -> no pulse; done set at k+6.
//  3 ONESHOT=1: second edge after done -> no pulse, missed=1.
//    ONESHOT=0: second edge -> second identical pulse, done strobes twice.
//  4 cancel in PULSE cycle 2 of width=8 -> rst_out inactive next cycle;
//    done=0; a new edge then produces a full pulse.
//  5 aresetn low mid-PULSE -> rst_out inactive without a clock edge.
//    trig held at TRIG_LEVEL through release -> exactly one sequence.
//  6 NUM_CH=3, all triggered same cycle with after=1/2/3, width=2 ->
//    staggered non-interfering pulses.
//    Change reset_after mid-WAIT -> timing unchanged.

Source files
------------

// File: rtl/eth_reset_pkg.sv
// Shared types and helpers for the Ethernet reset sequencer.
//   rst_state_t : per-channel sequencing state
//   cnt_w()     : shared counter width, large enough for either delay or width
package eth_reset_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    PULSE = 2'd2,
    DONE  = 2'd3
  } rst_state_t;

  function automatic int unsigned cnt_w(input int unsigned timer_w,
                                        input int unsigned width_w);
    return (timer_w > width_w) ? timer_w : width_w;
  endfunction

endpackage

// File: rtl/eth_reset_chan.sv
// One reset-sequencer channel: trigger edge detect, delay/width counter,
// sequencing FSM and status flags.
//   clk, aresetn : clock, async active-low reset
//   i_trig       : trigger, edge = transition into TRIG_LEVEL
//   i_cancel     : abort, returns channel to IDLE
//   i_after      : delay in cycles, latched on an accepted edge
//   i_width      : pulse width in cycles, latched on an accepted edge
//   o_rst_out    : reset pulse (polarity per OUT_ACTIVE_LOW)
//   o_busy       : in WAIT or PULSE
//   o_done       : sticky (ONESHOT) or 1-cycle strobe (re-armable)
//   o_missed     : sticky, edge arrived while the channel could not accept it
module eth_reset_chan
  import eth_reset_pkg::*;
#(
  parameter int unsigned TIMER_W        = 14,
  parameter int unsigned WIDTH_W        = 14,
  parameter bit          TRIG_LEVEL     = 1'b0,
  parameter bit          OUT_ACTIVE_LOW = 1'b0,
  parameter bit          ONESHOT        = 1'b1
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               i_trig,
  input  logic               i_cancel,
  input  logic [TIMER_W-1:0] i_after,
  input  logic [WIDTH_W-1:0] i_width,
  output logic               o_rst_out,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_missed
);

  localparam int unsigned CNT_W = cnt_w(TIMER_W, WIDTH_W);

  rst_state_t         r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt, w_cnt_nxt;
  logic [TIMER_W-1:0] r_after, w_after_nxt;
  logic [WIDTH_W-1:0] r_width, w_width_nxt;
  logic               r_fire, w_fire_nxt;
  logic               r_trig_prev;
  logic               r_rst_out, w_rst_out_nxt;
  logic               r_busy, w_busy_nxt;
  logic               r_done, w_done_nxt;
  logic               r_missed, w_missed_nxt;

  logic               w_edge;
  logic               w_armed;
  rst_state_t         w_launch_state, w_pulse_state;
  logic [CNT_W-1:0]   w_launch_cnt, w_pulse_cnt;

  assign w_edge = (i_trig == TRIG_LEVEL) && (r_trig_prev != TRIG_LEVEL);

  // An accepted edge only latches the parameters and raises r_fire; the
  // sequence is launched one cycle later so rst_out lands at k+1+after.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_after_nxt    = r_after;
    w_width_nxt    = r_width;
    w_fire_nxt     = 1'b0;
    w_missed_nxt   = r_missed;
    w_pulse_state  = DONE;
    w_pulse_cnt    = '0;
    w_launch_state = DONE;
    w_launch_cnt   = '0;

    // Entry into PULSE, skipped entirely for a zero width
    if (r_width != '0) begin
      w_pulse_state = PULSE;
      w_pulse_cnt   = CNT_W'(r_width);
    end
    // Entry from IDLE, skipping WAIT for a zero delay
    if (r_after != '0) begin
      w_launch_state = WAIT;
      w_launch_cnt   = CNT_W'(r_after);
    end else begin
      w_launch_state = w_pulse_state;
      w_launch_cnt   = w_pulse_cnt;
    end

    w_armed = (r_state == IDLE) || ((r_state == DONE) && !ONESHOT);

    if (i_cancel) begin
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end else if (r_fire) begin
      w_state_nxt = w_launch_state;
      w_cnt_nxt   = w_launch_cnt;
    end else begin
      if (w_edge) begin
        if (w_armed) begin
          w_after_nxt = i_after;
          w_width_nxt = i_width;
          w_fire_nxt  = 1'b1;
        end else begin
          w_missed_nxt = 1'b1;
        end
      end
      case (r_state)
        WAIT: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = w_pulse_state;
            w_cnt_nxt   = w_pulse_cnt;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        PULSE: begin
          if (r_cnt == CNT_W'(1)) begin
            w_state_nxt = DONE;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt - CNT_W'(1);
          end
        end
        DONE: begin
          if (!ONESHOT) begin
            w_state_nxt = IDLE;
          end
        end
        default: ;
      endcase
    end

    // Outputs track the next state so they change on the same edge as it
    w_busy_nxt    = (w_state_nxt == WAIT) || (w_state_nxt == PULSE);
    w_rst_out_nxt = (w_state_nxt == PULSE) ^ OUT_ACTIVE_LOW;
    w_done_nxt    = ONESHOT ? (r_done || (w_state_nxt == DONE))
                            : (w_state_nxt == DONE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_after     <= '0;
      r_width     <= '0;
      r_fire      <= 1'b0;
      r_trig_prev <= ~TRIG_LEVEL;
      r_rst_out   <= OUT_ACTIVE_LOW;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_missed    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_after     <= w_after_nxt;
      r_width     <= w_width_nxt;
      r_fire      <= w_fire_nxt;
      r_trig_prev <= i_trig;
      r_rst_out   <= w_rst_out_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_missed    <= w_missed_nxt;
    end
  end

  assign o_rst_out = r_rst_out;
  assign o_busy    = r_busy;
  assign o_done    = r_done;
  assign o_missed  = r_missed;

endmodule

// File: rtl/eth_reset_sequencer.sv
// Multi-channel programmable reset-pulse generator for the Ethernet path.
// Each channel independently delays after a trigger edge, then pulses.
//   clk, aresetn : clock, async active-low reset
//   trig         : per-channel trigger
//   cancel       : per-channel abort
//   reset_after  : per-channel delay, ch i at [i*TIMER_W +: TIMER_W]
//   reset_width  : per-channel pulse width, ch i at [i*WIDTH_W +: WIDTH_W]
//   rst_out      : per-channel reset pulse
//   busy, done, missed : per-channel status
module eth_reset_sequencer #(
  parameter int unsigned NUM_CH         = 3,
  parameter int unsigned TIMER_W        = 14,
  parameter int unsigned WIDTH_W        = 14,
  parameter bit          TRIG_LEVEL     = 1'b0,
  parameter bit          OUT_ACTIVE_LOW = 1'b0,
  parameter bit          ONESHOT        = 1'b1
) (
  input  logic                      clk,
  input  logic                      aresetn,
  input  logic [NUM_CH-1:0]         trig,
  input  logic [NUM_CH-1:0]         cancel,
  input  logic [NUM_CH*TIMER_W-1:0] reset_after,
  input  logic [NUM_CH*WIDTH_W-1:0] reset_width,
  output logic [NUM_CH-1:0]         rst_out,
  output logic [NUM_CH-1:0]         busy,
  output logic [NUM_CH-1:0]         done,
  output logic [NUM_CH-1:0]         missed
);

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    eth_reset_chan #(
      .TIMER_W       (TIMER_W),
      .WIDTH_W       (WIDTH_W),
      .TRIG_LEVEL    (TRIG_LEVEL),
      .OUT_ACTIVE_LOW(OUT_ACTIVE_LOW),
      .ONESHOT       (ONESHOT)
    ) u_chan (
      .clk      (clk),
      .aresetn  (aresetn),
      .i_trig   (trig[g]),
      .i_cancel (cancel[g]),
      .i_after  (reset_after[g*TIMER_W +: TIMER_W]),
      .i_width  (reset_width[g*WIDTH_W +: WIDTH_W]),
      .o_rst_out(rst_out[g]),
      .o_busy   (busy[g]),
      .o_done   (done[g]),
      .o_missed (missed[g])
    );
  end

endmodule

// File: tb/tb_eth_reset_sequencer.sv
// Directed self-checking bench: one one-shot instance (u_a) and one
// re-armable instance (u_b), both with active-low triggers and
// active-high rst_out.
module tb_eth_reset_sequencer;

  localparam int unsigned TW = 14;
  localparam int unsigned WW = 14;

  logic          clk = 1'b0;
  logic          aresetn;
  logic [2:0]    trig_a, cancel_a, trig_b, cancel_b;
  logic [3*TW-1:0] after_a, after_b;
  logic [3*WW-1:0] width_a, width_b;
  logic [2:0]    rst_a, busy_a, done_a, missed_a;
  logic [2:0]    rst_b, busy_b, done_b, missed_b;
  logic [2:0]    e_rst, e_busy, e_done;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  eth_reset_sequencer #(
    .NUM_CH(3), .TIMER_W(TW), .WIDTH_W(WW),
    .TRIG_LEVEL(1'b0), .OUT_ACTIVE_LOW(1'b0), .ONESHOT(1'b1)
  ) u_a (
    .clk(clk), .aresetn(aresetn), .trig(trig_a), .cancel(cancel_a),
    .reset_after(after_a), .reset_width(width_a),
    .rst_out(rst_a), .busy(busy_a), .done(done_a), .missed(missed_a)
  );

  eth_reset_sequencer #(
    .NUM_CH(3), .TIMER_W(TW), .WIDTH_W(WW),
    .TRIG_LEVEL(1'b0), .OUT_ACTIVE_LOW(1'b0), .ONESHOT(1'b0)
  ) u_b (
    .clk(clk), .aresetn(aresetn), .trig(trig_b), .cancel(cancel_b),
    .reset_after(after_b), .reset_width(width_b),
    .rst_out(rst_b), .busy(busy_b), .done(done_b), .missed(missed_b)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Edge sampled at j=1; rst active j in [2+after, 1+after+width],
  // busy j in [2, 1+after+width], done at j = 2+after+width.
  // Inputs are scrambled after the edge to confirm they were latched.
  task automatic seq_check(input bit on_b, input int ch, input int after,
                           input int width, input string tag);
    logic er, eb, ed;
    if (on_b) begin
      after_b[ch*TW +: TW] = TW'(after);
      width_b[ch*WW +: WW] = WW'(width);
      trig_b[ch] = 1'b0;
    end else begin
      after_a[ch*TW +: TW] = TW'(after);
      width_a[ch*WW +: WW] = WW'(width);
      trig_a[ch] = 1'b0;
    end
    for (int j = 1; j <= after + width + 3; j++) begin
      step();
      if (j == 2) begin
        if (on_b) begin
          after_b[ch*TW +: TW] = 14'h2AAA;
          width_b[ch*WW +: WW] = 14'h1555;
        end else begin
          after_a[ch*TW +: TW] = 14'h2AAA;
          width_a[ch*WW +: WW] = 14'h1555;
        end
      end
      er = (j >= 2 + after) && (j <= 1 + after + width);
      eb = (j >= 2) && (j <= 1 + after + width);
      ed = on_b ? (j == 2 + after + width) : (j >= 2 + after + width);
      chk({tag, "_rst"},  32'(on_b ? rst_b[ch]  : rst_a[ch]),  32'(er));
      chk({tag, "_busy"}, 32'(on_b ? busy_b[ch] : busy_a[ch]), 32'(eb));
      chk({tag, "_done"}, 32'(on_b ? done_b[ch] : done_a[ch]), 32'(ed));
    end
    if (on_b) trig_b[ch] = 1'b1;
    else      trig_a[ch] = 1'b1;
    step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    aresetn  = 1'b0;
    trig_a   = 3'b111;
    trig_b   = 3'b111;
    cancel_a = 3'b000;
    cancel_b = 3'b000;
    after_a  = '0;
    after_b  = '0;
    width_a  = '0;
    width_b  = '0;
    repeat (3) step();

    // Reset state
    chk("reset_rst_a",    32'(rst_a),    32'd0);
    chk("reset_busy_a",   32'(busy_a),   32'd0);
    chk("reset_done_a",   32'(done_a),   32'd0);
    chk("reset_missed_a", 32'(missed_a), 32'd0);
    chk("reset_rst_b",    32'(rst_b),    32'd0);
    chk("reset_busy_b",   32'(busy_b),   32'd0);
    aresetn = 1'b1;
    repeat (2) step();

    // Basic sequence, one-shot
    seq_check(1'b0, 0, 3, 4, "t1");

    // Second edge on a spent one-shot channel
    chk("t3a_missed_pre", 32'(missed_a[0]), 32'd0);
    trig_a[0] = 1'b0;
    for (int j = 1; j <= 8; j++) begin
      step();
      chk("t3a_no_rst",  32'(rst_a[0]),  32'd0);
      chk("t3a_no_busy", 32'(busy_a[0]), 32'd0);
    end
    chk("t3a_missed", 32'(missed_a[0]), 32'd1);
    chk("t3a_done",   32'(done_a[0]),   32'd1);
    trig_a[0] = 1'b1;
    step();

    // Cancel in the second PULSE cycle, then a full re-run
    after_a[1*TW +: TW] = 14'd2;
    width_a[1*WW +: WW] = 14'd8;
    trig_a[1] = 1'b0;
    repeat (4) step();
    chk("t4_pulse_c1", 32'(rst_a[1]), 32'd1);
    step();
    chk("t4_pulse_c2", 32'(rst_a[1]), 32'd1);
    cancel_a[1] = 1'b1;
    step();
    chk("t4_cancel_rst",  32'(rst_a[1]),  32'd0);
    chk("t4_cancel_busy", 32'(busy_a[1]), 32'd0);
    chk("t4_cancel_done", 32'(done_a[1]), 32'd0);
    cancel_a[1] = 1'b0;
    trig_a[1]   = 1'b1;
    step();
    chk("t4_missed", 32'(missed_a[1]), 32'd0);
    seq_check(1'b0, 1, 2, 8, "t4_rerun");

    // Zero delay, single-cycle pulse
    seq_check(1'b0, 2, 0, 1, "t2a");

    // Zero width on the re-armable instance
    seq_check(1'b1, 0, 5, 0, "t2b");

    // Re-armable: two identical sequences
    seq_check(1'b1, 1, 1, 2, "t3b_first");
    seq_check(1'b1, 1, 1, 2, "t3b_second");
    chk("t3b_missed", 32'(missed_b), 32'd0);

    // All channels triggered together, staggered delays
    after_b = {14'd3, 14'd2, 14'd1};
    width_b = {14'd2, 14'd2, 14'd2};
    trig_b  = 3'b000;
    for (int j = 1; j <= 8; j++) begin
      step();
      for (int i = 0; i < 3; i++) begin
        e_rst[i]  = (j >= 3 + i) && (j <= 4 + i);
        e_busy[i] = (j >= 2) && (j <= 4 + i);
        e_done[i] = (j == 5 + i);
      end
      chk("t6_rst",  32'(rst_b),  32'(e_rst));
      chk("t6_busy", 32'(busy_b), 32'(e_busy));
      chk("t6_done", 32'(done_b), 32'(e_done));
    end
    trig_b = 3'b111;
    step();

    // Cancel and edge in the same cycle: edge dropped
    cancel_b[0] = 1'b1;
    trig_b[0]   = 1'b0;
    step();
    cancel_b[0] = 1'b0;
    for (int j = 1; j <= 4; j++) begin
      step();
      chk("tce_busy", 32'(busy_b[0]), 32'd0);
      chk("tce_rst",  32'(rst_b[0]),  32'd0);
    end
    chk("tce_missed", 32'(missed_b[0]), 32'd0);
    trig_b[0] = 1'b1;
    step();

    // All-ones width: exact terminal count
    after_b[1*TW +: TW] = 14'd0;
    width_b[1*WW +: WW] = 14'h3FFF;
    trig_b[1] = 1'b0;
    step();
    repeat (16383) step();
    chk("tmax_rst_last", 32'(rst_b[1]),  32'd1);
    chk("tmax_busy_last", 32'(busy_b[1]), 32'd1);
    step();
    chk("tmax_rst_end",  32'(rst_b[1]),  32'd0);
    chk("tmax_busy_end", 32'(busy_b[1]), 32'd0);
    chk("tmax_done",     32'(done_b[1]), 32'd1);
    trig_b[1] = 1'b1;
    step();

    // Async reset mid-PULSE, then trigger held through release
    after_b[2*TW +: TW] = 14'd1;
    width_b[2*WW +: WW] = 14'd6;
    trig_b[2] = 1'b0;
    repeat (5) step();
    chk("t5_pulse", 32'(rst_b[2]), 32'd1);
    #2;
    aresetn = 1'b0;
    #1;
    chk("t5_async_rst",  32'(rst_b[2]),  32'd0);
    chk("t5_async_busy", 32'(busy_b),    32'd0);
    chk("t5_clr_done",   32'(done_a),    32'd0);
    chk("t5_clr_missed", 32'(missed_a),  32'd0);
    step();
    aresetn = 1'b1;
    seq_check(1'b1, 2, 1, 6, "t5_held");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
